// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for the word-addressed data RAM.
// Handles fault decode, lane steering, load extension and a valid/ready response.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 2305
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_is_store,
  output logic        mem_is_load,
  output logic [3:0]  mem_w_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STORE = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_LWAIT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        resp_valid_d, resp_err_d, mem_is_store_d, mem_is_load_d;
  logic [31:0] resp_rdata_d, mem_addr_d, mem_w_data_d;
  logic [3:0]  mem_w_enable_d;

  logic [31:0] word_idx;
  logic        misaligned, illegal, out_of_range, fault;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;

  assign req_ready = (state_q == S_IDLE);
  assign word_idx  = {2'b00, req_addr[31:2]};

  // Request fault decode
  always_comb begin
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal      = 1'b1;
    if (req_store) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        default:                illegal = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
    out_of_range = (word_idx >= MEM_WORDS);
    fault        = misaligned || illegal || out_of_range;
  end

  // Load lane extraction and extension
  always_comb begin
    rd_byte = mem_r_data[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_fmt = {24'h000000, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_fmt = {16'h0000, rd_half};
      default: load_fmt = mem_r_data;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d        = state_q;
    f3_d           = f3_q;
    lane_d         = lane_q;
    resp_valid_d   = resp_valid;
    resp_err_d     = resp_err;
    resp_rdata_d   = resp_rdata;
    mem_is_store_d = 1'b0;
    mem_is_load_d  = 1'b0;
    mem_w_enable_d = 4'b0000;
    mem_addr_d     = mem_addr;
    mem_w_data_d   = mem_w_data;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d   = req_funct3;
          lane_d = req_addr[1:0];
          if (fault) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (req_store) begin
            state_d        = S_STORE;
            mem_is_store_d = 1'b1;
            mem_addr_d     = word_idx;
            case (req_funct3[1:0])
              2'b00: begin
                mem_w_enable_d = 4'b0001 << req_addr[1:0];
                mem_w_data_d   = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                mem_w_enable_d = req_addr[1] ? 4'b1100 : 4'b0011;
                mem_w_data_d   = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_w_enable_d = 4'b1111;
                mem_w_data_d   = req_wdata;
              end
            endcase
          end else begin
            state_d       = S_LOAD;
            mem_is_load_d = 1'b1;
            mem_addr_d    = word_idx;
          end
        end
      end
      S_STORE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
      S_LOAD: state_d = S_LWAIT;
      S_LWAIT: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_fmt;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= 32'h0;
      mem_is_store <= 1'b0;
      mem_is_load  <= 1'b0;
      mem_w_enable <= 4'b0000;
      mem_addr     <= 32'h0;
      mem_w_data   <= 32'h0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      resp_valid   <= resp_valid_d;
      resp_err     <= resp_err_d;
      resp_rdata   <= resp_rdata_d;
      mem_is_store <= mem_is_store_d;
      mem_is_load  <= mem_is_load_d;
      mem_w_enable <= mem_w_enable_d;
      mem_addr     <= mem_addr_d;
      mem_w_data   <= mem_w_data_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;
  localparam int unsigned MEM_WORDS = 2305;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_is_store, mem_is_load;
  logic [3:0]  mem_w_enable;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram     [0:MEM_WORDS-1];
  logic [7:0]  ref_mem [0:MEM_WORDS*4-1];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_is_store(mem_is_store), .mem_is_load(mem_is_load),
    .mem_w_enable(mem_w_enable), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  // Synchronous RAM stub with one-cycle read latency
  always @(posedge clk) begin
    if (mem_is_store) begin
      for (int i = 0; i < 4; i++)
        if (mem_w_enable[i]) ram[mem_addr[11:0]][8*i +: 8] <= mem_w_data[8*i +: 8];
    end
    if (mem_is_load) mem_r_data <= ram[mem_addr[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int bp);
    int          size, lat, n_st, n_ld, base;
    logic        err, got;
    logic [31:0] exp_rd, exp_wd, word;
    logic [3:0]  exp_we;
    longint unsigned v;
    int          exp_lat;

    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    word = addr >> 2;
    if (st) err = (f3 > 3'd2);
    else    err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((addr % size) != 0) err = 1'b1;
    if (word >= MEM_WORDS) err = 1'b1;
    exp_rd = 32'h0; exp_we = 4'b0000; exp_wd = 32'h0;
    exp_lat = err ? 1 : (st ? 2 : 3);
    if (!err) begin
      base = int'(addr);
      if (st) begin
        for (int i = 0; i < 4; i++) begin
          exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
          if (i >= base % 4 && i < base % 4 + size) exp_we[i] = 1'b1;
        end
        for (int k = 0; k < size; k++) ref_mem[base + k] = wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < size; k++) v = v | (longint'(ref_mem[base + k]) << (8*k));
        if (!f3[2] && size < 4 && (((v >> (8*size - 1)) & 1) != 0))
          v = v | ~((64'd1 << (8*size)) - 1);
        exp_rd = v[31:0];
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = (bp == 0);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; got = 1'b0; n_st = 0; n_ld = 0;
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (mem_is_store) begin
        n_st++;
        check("st_we", {28'b0, mem_w_enable}, {28'b0, exp_we});
        check("st_wdata", mem_w_data, exp_wd);
        check("st_addr", mem_addr, word);
      end
      if (mem_is_load) begin
        n_ld++;
        check("ld_we", {28'b0, mem_w_enable}, 32'd0);
        check("ld_addr", mem_addr, word);
      end
      if (mem_is_store && mem_is_load) check("strobe_excl", 32'd1, 32'd0);
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", lat, exp_lat);
    check("resp_err", {31'b0, resp_err}, {31'b0, err});
    check("resp_rdata", resp_rdata, exp_rd);
    check("n_store_strobe", n_st, (!err && st) ? 1 : 0);
    check("n_load_strobe", n_ld, (!err && !st) ? 1 : 0);
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, exp_rd);
      check("bp_err", {31'b0, resp_err}, {31'b0, err});
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_no_store", {31'b0, mem_is_store}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("resp_done", {31'b0, resp_valid}, 32'd0);
    check("req_ready_back", {31'b0, req_ready}, 32'd1);
    check("no_stray_store", {31'b0, mem_is_store}, 32'd0);
  endtask

  logic [2:0] f3_tab [0:9];
  logic [31:0] r_word;

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] = 32'h0;
    for (int i = 0; i < int'(MEM_WORDS) * 4; i++) ref_mem[i] = 8'h00;
    f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;
    f3_tab[5] = 3'd0; f3_tab[6] = 3'd1; f3_tab[7] = 3'd2; f3_tab[8] = 3'd3; f3_tab[9] = 3'd6;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_strobes", {30'b0, mem_is_store, mem_is_load}, 32'd0);
    check("rst_mem_we", {28'b0, mem_w_enable}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_w_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    do_req(1'b1, 3'b010, 32'h100, 32'h12F45678, 0);
    do_req(1'b0, 3'b000, 32'h102, 32'h0, 0);
    do_req(1'b0, 3'b100, 32'h102, 32'h0, 0);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0);
    do_req(1'b1, 3'b000, 32'h103, 32'h000000AB, 0);
    do_req(1'b0, 3'b010, 32'h106, 32'h0, 0);
    do_req(1'b1, 3'b001, 32'h2404, 32'h1234, 0);
    do_req(1'b1, 3'b100, 32'h100, 32'h55, 0);
    do_req(1'b0, 3'b101, 32'h101, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h2400, 32'hCAFEF00D, 0);
    do_req(1'b0, 3'b010, 32'h2400, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 3);

    // Reset while a load is in LOAD
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_load", {31'b0, mem_is_load}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_load", {31'b0, mem_is_load}, 32'd0);
    check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 0);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) r_word = $urandom_range(MEM_WORDS - 2, MEM_WORDS + 3);
      else                           r_word = $urandom_range(32'h40, 32'h47);
      do_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 9)],
             (r_word << 2) + 32'($urandom_range(0, 3)), $urandom,
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator for the word-addressed data RAM of the five-stage RV32I core. It accepts one load or store per handshake from the pipeline and converts the byte address to a word index. It drives the RAM's command signals (store/load strobes, 4-bit byte-write enable, word address, lane-replicated write data) and captures the RAM's one-cycle-latency read data. Loaded bytes and halfwords are extracted and sign- or zero-extended, and the result is returned on a valid/ready response channel.

Parameters:
MEM_WORDS, 2305, number of 32-bit words in the data RAM; a word index >= MEM_WORDS is an access fault

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store source (rs2)
resp_valid  out  1  response present
resp_ready  in  1  pipeline accepts response
resp_rdata  out  32  formatted load result (0 for stores and faults)
resp_err  out  1  misaligned, illegal-funct3 or out-of-range access
mem_is_store  out  1  RAM write strobe
mem_is_load  out  1  RAM read strobe
mem_w_enable  out  4  RAM byte-write enables, bit i = byte lane i
mem_addr  out  32  RAM word index = {2'b0, req_addr[31:2]}
mem_w_data  out  32  RAM write data, lane-replicated
mem_r_data  in  32  RAM read data, valid the cycle after mem_is_load

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; all mem_* outputs=0.
- Reset mid-operation: an in-flight command or response is dropped and no write occurs after reset assertion.
- All outputs are registered except req_ready, which is decoded from state.
- FSM states: IDLE, STORE, LOAD, LWAIT, RESP.
- IDLE, when req_valid (req_ready=1), latches funct3, addr[1:0] and store/load. It then checks for a fault:
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - illegal funct3: loads other than 000/001/010/100/101, stores other than 000/001/010;
  - out of range: addr[31:2] >= MEM_WORDS.
- Fault path: next state RESP with resp_err=1 and resp_rdata=0. No mem strobe is ever asserted.
- Store path: next state STORE. For exactly that one cycle: mem_is_store=1, mem_addr=word index, and enables/data as follows.
  - SB: mem_w_enable = 1<<addr[1:0]; mem_w_data = {4{wdata[7:0]}}.
  - SH: mem_w_enable = addr[1] ? 1100 : 0011; mem_w_data = {2{wdata[15:0]}}.
  - SW: mem_w_enable = 1111; mem_w_data = wdata.
  - Then RESP with resp_err=0 and resp_rdata=0.
- Load path: next state LOAD, with mem_is_load=1 and mem_w_enable=0 for one cycle. Then LWAIT: the RAM data is valid and is formatted into resp_rdata on the exit edge. Then RESP.
  - B: sign-extend byte lane addr[1:0]. BU: zero-extend the same lane.
  - H: sign-extend halfword lane addr[1]. HU: zero-extend the same lane.
  - W: whole word.
- Strobe hygiene: mem_is_store and mem_is_load are never high together, and each returns to 0 in every state other than STORE/LOAD. mem_addr and mem_w_data hold their last value.
- Latency, counted with the accept edge as edge 0:
  - store or fault: resp_valid high from edge 1 (fault) or edge 2 (store);
  - load: resp_valid high from edge 3.
- RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready=1. It returns to IDLE on the next edge with resp_valid=0.
- Request/response overlap: req_ready=0 in RESP, so a request offered alongside resp_ready is not accepted until the following IDLE cycle. Minimum issue interval: 3 cycles for stores, 4 for loads.
- req_valid while busy is ignored. The pipeline keeps it asserted and stalls on !req_ready.

Test Plan:
- SB: addr 0x00000103, wdata 0x000000AB -> one cycle with mem_is_store=1, mem_addr=0x40, mem_w_enable=1000, mem_w_data=0xABABABAB; resp_valid at edge 2, resp_err=0.
- Loads from word 0x40 preloaded 0x12F45678:
  - LB at 0x102 -> 0xFFFFFFF4; LBU at 0x102 -> 0x000000F4;
  - LH at 0x102 -> 0x000012F4; LW at 0x100 -> 0x12F45678;
  - each resp_valid at edge 3, mem_is_load high exactly one cycle.
- Faults:
  - LW at 0x106 -> resp_err=1, resp_rdata=0 at edge 1, no mem strobe;
  - SH at 0x2404 (word 0x901) -> same fault behaviour;
  - store with funct3=100 -> same fault behaviour.
- Backpressure: LW with resp_ready low for 3 cycles -> resp_valid and data stable, req_ready=0, and a second req_valid is not accepted until the cycle after resp_ready.
- Reset: rst_n low during LOAD -> mem_is_load, resp_valid and req_ready=1 return to reset values immediately; after release a new SW at 0x0 writes 0xDEADBEEF and a subsequent LW returns 0xDEADBEEF.
